prio_burst_arbiter: RTL
=======================

// Module: prio_burst_arbiter
// PURPOSE
// - Registered N-channel priority arbiter selecting which memory block feeds the output mux.
// - Holds a grant on one non-empty block for up to MAX_BURST words, then re-arbitrates; empty blocks are skipped.
// - Drives one-hot and binary selects for the downstream stream-combining mux, replacing the fixed 12-input priority encoder.
// PARAMETERS
// - NCH       12  number of memory blocks / request channels (2..64)
// - MAX_BURST 16  max words consumed from one grant before forced re-arbitration (>=1)
// - SELW      $clog2(NCH)        binary select width (derived, do not override)
// - BW        $clog2(MAX_BURST)+1 burst counter width (derived)
// PORTS
// - clk        in   1     single clock, all logic on rising edge
// - reset_n    in   1     asynchronous, active-low reset
// - has_dat    in   NCH   bit i = block i holds data
// - adv        in   1     downstream consumed one word from granted block this cycle
// - gnt_valid  out  1     a grant is active; sel/sel_oh valid
// - sel_oh     out  NCH   one-hot grant; all-zero when gnt_valid=0
// - sel        out  SELW  binary index of granted block (0-based, no offset)
// - none       out  1     no block requested in the last arbitration
// - burst_cnt  out  BW    words consumed in current grant
// BEHAVIOUR
// - Reset (async assert, sync-safe deassert): state=IDLE, gnt_valid=0, sel_oh=0, sel=0, none=1, burst_cnt=0, rr_ptr=0.
// - States: IDLE, GRANT. All outputs registered.
// - Arbitration winner: lowest index with has_dat set (fixed mode); channel 0 highest priority.
// - IDLE: if |has_dat -> next edge: GRANT, gnt_valid=1, none=0, sel/sel_oh=winner, burst_cnt=0.
//   else stay IDLE, none=1. Latency has_dat -> gnt_valid: 1 cycle.
// - GRANT: adv=1 -> burst_cnt+1. adv ignored in IDLE.
// - Grant ends at edge where: (a) adv && burst_cnt==MAX_BURST-1 (limit), or (b) has_dat[sel]==0 (drained).
//   Simultaneous adv and drain: word counted, grant ends (drain).
// - On end: re-arbitrate same edge, no bubble. Limit case masks current channel unless it is the sole requester
//   (then re-granted, burst_cnt=0). Drained case: current channel excluded by has_dat.
//   No requester -> IDLE, gnt_valid=0, sel_oh=0, none=1, sel holds last value.
// - Requests on other channels never preempt an active grant.
// - burst_cnt never exceeds MAX_BURST-1; cleared on every new grant.
// - reset_n low mid-grant: all outputs to reset values immediately, no clock needed; grant lost.
// CONFIGURATION
// - ROUND_ROBIN_EN defined: priority starts at rr_ptr, search rr_ptr..NCH-1 then 0..rr_ptr-1;
//   on every grant to channel k, rr_ptr <= (k==NCH-1) ? 0 : k+1. Limit-case masking unchanged.
// - ROUND_ROBIN_EN undefined: fixed priority, channel 0 highest; rr_ptr logic absent.
// TESTING
// - Reset: reset_n=0 -> gnt_valid=0, sel_oh=0, sel=0, none=1, burst_cnt=0, asynchronously.
// - IDLE, has_dat=12'h0A0 -> next edge sel=5, sel_oh=12'h020, gnt_valid=1, none=0.
// - MAX_BURST=4, has_dat[2],[7] held, adv=1 continuous -> 4 words on sel=2, then sel=7 with no gnt_valid gap;
//   fixed mode returns to 2 after 4 words on 7.
// - Grant on ch3, adv=1 and has_dat[3] falls same cycle, no others -> burst_cnt incremented, next edge gnt_valid=0, none=1.
// - ROUND_ROBIN_EN, MAX_BURST=1, has_dat=all ones, adv=1 -> sel sequence 0,1,..,11,0,1 every cycle.
// - Sole requester ch9, MAX_BURST=2, adv=1 -> sel stays 9, burst_cnt 0,1,0,1, gnt_valid stays 1.

Source files
------------

// File: rtl/prio_burst_arbiter.sv
// prio_burst_arbiter: registered N-channel arbiter holding a grant for up to MAX_BURST words.
// Define ROUND_ROBIN_EN for rotating priority; without it channel 0 always has highest priority.
module prio_burst_arbiter #(
   parameter int NCH       = 12,
   parameter int MAX_BURST = 16,
   parameter int SELW      = $clog2(NCH),
   parameter int BW        = $clog2(MAX_BURST) + 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NCH-1:0]  has_dat,
   input  logic            adv,
   output logic            gnt_valid,
   output logic [NCH-1:0]  sel_oh,
   output logic [SELW-1:0] sel,
   output logic            none,
   output logic [BW-1:0]   burst_cnt
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t          state_q;
   state_t          state_d;
   logic [NCH-1:0]  sel_oh_d;
   logic [SELW-1:0] sel_d;
   logic            none_d;
   logic [BW-1:0]   cnt_d;
   logic [NCH-1:0]  req;
   logic [NCH-1:0]  masked;
   logic            arb;
   logic            limit;
   logic            drained;
   logic [SELW-1:0] win;
   logic [SELW-1:0] start;
`ifdef ROUND_ROBIN_EN
   logic [SELW-1:0] rr_ptr;
   logic [SELW-1:0] rr_ptr_d;
`endif

   // First set bit of r, searching circularly from index first.
   function automatic logic [SELW-1:0] pick(input logic [NCH-1:0] r, input logic [SELW-1:0] first);
      logic [SELW-1:0] idx;
      logic [SELW-1:0] ci;
      logic            found;
      int              c;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         c = int'(first) + i;
         if (c >= NCH) c = c - NCH;
         ci = SELW'(c);
         if (!found && r[ci]) begin
            found = 1'b1;
            idx   = ci;
         end
      end
      return idx;
   endfunction

   assign gnt_valid = (state_q == GRANT);
   assign limit     = adv && (burst_cnt == BW'(MAX_BURST - 1));
   assign drained   = !has_dat[sel];

   always_comb begin
      state_d  = state_q;
      sel_oh_d = sel_oh;
      sel_d    = sel;
      none_d   = none;
      cnt_d    = burst_cnt;
      req      = has_dat;
      masked   = has_dat & ~sel_oh;
      arb      = 1'b0;
`ifdef ROUND_ROBIN_EN
      rr_ptr_d = rr_ptr;
      start    = rr_ptr;
`else
      start    = '0;
`endif

      case (state_q)
         IDLE: arb = 1'b1;
         GRANT: begin
            if (limit || drained) begin
               arb = 1'b1;
               // A full burst yields to others, but a sole requester is simply re-granted.
               if (!drained && (|masked)) req = masked;
               // Word is still counted if the grant falls back to IDLE; capped at the limit.
               if (adv && !limit) cnt_d = burst_cnt + BW'(1);
            end else begin
               cnt_d = burst_cnt + BW'(adv);
            end
         end
         default: state_d = IDLE;
      endcase

      win = pick(req, start);
      if (arb) begin
         if (|req) begin
            state_d  = GRANT;
            sel_d    = win;
            sel_oh_d = NCH'(1) << win;
            none_d   = 1'b0;
            cnt_d    = '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr_d = (win == SELW'(NCH - 1)) ? '0 : win + SELW'(1);
`endif
         end else begin
            state_d  = IDLE;
            sel_oh_d = '0;
            none_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         sel_oh    <= '0;
         sel       <= '0;
         none      <= 1'b1;
         burst_cnt <= '0;
      end else begin
         state_q   <= state_d;
         sel_oh    <= sel_oh_d;
         sel       <= sel_d;
         none      <= none_d;
         burst_cnt <= cnt_d;
      end
   end

`ifdef ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rr_ptr <= '0;
      else          rr_ptr <= rr_ptr_d;
   end
`endif

endmodule
